// File: rtl/arp_cache_assoc_if.sv
// Query / write / clear bus between a requester and the ARP cache.
interface arp_cache_assoc_if;
  logic        query_request_valid;
  logic        query_request_ready;
  logic [31:0] query_request_ip;
  logic        query_response_valid;
  logic        query_response_ready;
  logic        query_response_error;
  logic [47:0] query_response_mac;
  logic        write_request_valid;
  logic        write_request_ready;
  logic [31:0] write_request_ip;
  logic [47:0] write_request_mac;
  logic        clear_cache;

  modport master (
    output query_request_valid, query_request_ip, query_response_ready,
           write_request_valid, write_request_ip, write_request_mac, clear_cache,
    input  query_request_ready, query_response_valid, query_response_error,
           query_response_mac, write_request_ready
  );

  modport slave (
    input  query_request_valid, query_request_ip, query_response_ready,
           write_request_valid, write_request_ip, write_request_mac, clear_cache,
    output query_request_ready, query_response_valid, query_response_error,
           query_response_mac, write_request_ready
  );
endinterface

// File: rtl/arp_cache_assoc.sv
// 2-way set-associative IPv4->MAC cache with one FSM serialising all accesses.
module arp_cache_assoc #(
  parameter int unsigned CACHE_ADDR_WIDTH = 9
) (
  input logic               clk,
  input logic               rst_n,
  arp_cache_assoc_if.slave  bus
);
  localparam int unsigned AW     = CACHE_ADDR_WIDTH;
  localparam int unsigned NSETS  = 32'(1) << AW;
  localparam int unsigned NCHUNK = (32 + AW - 1) / AW;
  localparam int unsigned PW     = NCHUNK * AW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_Q_READ   = 3'd1;
  localparam logic [2:0] S_Q_RESP   = 3'd2;
  localparam logic [2:0] S_W_READ   = 3'd3;
  localparam logic [2:0] S_W_COMMIT = 3'd4;
  localparam logic [2:0] S_CLEAR    = 3'd5;

  // Set index: XOR-fold of AW-bit chunks, last chunk zero-padded.
  function automatic logic [AW-1:0] f_hash(input logic [31:0] ip);
    logic [AW-1:0] h;
    logic [PW-1:0] p;
    h = '0;
    p = PW'(ip);
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      h = h ^ p[AW-1:0];
      p = p >> AW;
    end
    return h;
  endfunction

  logic [2:0]    r_state, w_next;
  logic          r_phase;
  logic [AW-1:0] r_idx, r_clr_idx;
  logic [31:0]   r_ip;
  logic [47:0]   r_mac;
  logic          r_clr_pend;
  logic          r_resp_valid, r_resp_err;
  logic [47:0]   r_resp_mac;

  logic          r_mv0 [NSETS];
  logic          r_mv1 [NSETS];
  logic [31:0]   r_mip0 [NSETS];
  logic [31:0]   r_mip1 [NSETS];
  logic [47:0]   r_mmac0 [NSETS];
  logic [47:0]   r_mmac1 [NSETS];
  logic          r_lru [NSETS];

  logic          r_rd_v0, r_rd_v1, r_rd_lru;
  logic [31:0]   r_rd_ip0, r_rd_ip1;
  logic [47:0]   r_rd_mac0, r_rd_mac1;

  logic          w_hit0, w_hit1, w_q_hit, w_q_way, w_wr_way, w_clr_go;

  assign w_hit0   = r_rd_v0 && (r_rd_ip0 == r_ip);
  assign w_hit1   = r_rd_v1 && (r_rd_ip1 == r_ip);
  assign w_q_hit  = w_hit0 || w_hit1;
  assign w_q_way  = !w_hit0;
  assign w_wr_way = w_hit0 ? 1'b0 : w_hit1 ? 1'b1 : !r_rd_v0 ? 1'b0 : !r_rd_v1 ? 1'b1 : r_rd_lru;
  assign w_clr_go = bus.clear_cache || r_clr_pend;

  assign bus.query_request_ready  = (r_state == S_IDLE) && !bus.clear_cache && !bus.write_request_valid;
  assign bus.write_request_ready  = (r_state == S_IDLE) && !bus.clear_cache;
  assign bus.query_response_valid = r_resp_valid;
  assign bus.query_response_error = r_resp_err;
  assign bus.query_response_mac   = r_resp_mac;

  // State register; reset starts a full invalidation sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.clear_cache)              w_next = S_CLEAR;
        else if (bus.write_request_valid) w_next = S_W_READ;
        else if (bus.query_request_valid) w_next = S_Q_READ;
      end
      S_Q_READ:   if (r_phase) w_next = S_Q_RESP;
      S_Q_RESP:   if (bus.query_response_ready) w_next = w_clr_go ? S_CLEAR : S_IDLE;
      S_W_READ:   w_next = S_W_COMMIT;
      S_W_COMMIT: w_next = w_clr_go ? S_CLEAR : S_IDLE;
      S_CLEAR:    if (!bus.clear_cache && (r_clr_idx == AW'(NSETS - 1))) w_next = S_IDLE;
      default:    w_next = S_CLEAR;
    endcase
  end

  // Request capture, sweep pointer, pending clear and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= 1'b0;
      r_idx        <= '0;
      r_ip         <= '0;
      r_mac        <= '0;
      r_clr_idx    <= '0;
      r_clr_pend   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_mac   <= '0;
    end else begin
      r_phase <= (r_state == S_Q_READ) && !r_phase;
      if ((r_state == S_IDLE) && !bus.clear_cache) begin
        if (bus.write_request_valid) begin
          r_ip  <= bus.write_request_ip;
          r_mac <= bus.write_request_mac;
          r_idx <= f_hash(bus.write_request_ip);
        end else if (bus.query_request_valid) begin
          r_ip  <= bus.query_request_ip;
          r_idx <= f_hash(bus.query_request_ip);
        end
      end
      if ((w_next == S_CLEAR) && ((r_state != S_CLEAR) || bus.clear_cache))
        r_clr_idx <= '0;
      else if (r_state == S_CLEAR)
        r_clr_idx <= r_clr_idx + AW'(1);
      if (w_next == S_CLEAR)
        r_clr_pend <= 1'b0;
      else if (bus.clear_cache && (r_state != S_IDLE))
        r_clr_pend <= 1'b1;
      if ((r_state == S_Q_READ) && r_phase) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= !w_q_hit;
        r_resp_mac   <= w_q_hit ? (w_hit0 ? r_rd_mac0 : r_rd_mac1) : 48'h0;
      end else if ((r_state == S_Q_RESP) && bus.query_response_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Storage: one synchronous read port, one write port (sweep, commit or lru touch).
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mv0[r_clr_idx] <= 1'b0;
      r_mv1[r_clr_idx] <= 1'b0;
      r_lru[r_clr_idx] <= 1'b0;
    end
    if (r_state == S_W_COMMIT) begin
      if (w_wr_way) begin
        r_mv1[r_idx]   <= 1'b1;
        r_mip1[r_idx]  <= r_ip;
        r_mmac1[r_idx] <= r_mac;
      end else begin
        r_mv0[r_idx]   <= 1'b1;
        r_mip0[r_idx]  <= r_ip;
        r_mmac0[r_idx] <= r_mac;
      end
      r_lru[r_idx] <= !w_wr_way;
    end
    if ((r_state == S_Q_READ) && r_phase && w_q_hit)
      r_lru[r_idx] <= !w_q_way;
    if (((r_state == S_Q_READ) && !r_phase) || (r_state == S_W_READ)) begin
      r_rd_v0   <= r_mv0[r_idx];
      r_rd_v1   <= r_mv1[r_idx];
      r_rd_ip0  <= r_mip0[r_idx];
      r_rd_ip1  <= r_mip1[r_idx];
      r_rd_mac0 <= r_mmac0[r_idx];
      r_rd_mac1 <= r_mmac1[r_idx];
      r_rd_lru  <= r_lru[r_idx];
    end
  end
endmodule

// File: tb/tb_arp_cache_assoc.sv
// Scoreboard bench for arp_cache_assoc against a recency-list cache model.
module tb_arp_cache_assoc;
  localparam int unsigned AW    = 4;
  localparam int unsigned NSETS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arp_cache_assoc_if bus ();
  arp_cache_assoc #(.CACHE_ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Model: each set is a recency list (front = least recently used), capacity 2.
  typedef struct packed { logic [31:0] ip; logic [47:0] mac; } ent_t;
  typedef struct packed { logic err; logic [47:0] mac; } resp_t;
  ent_t  m_set [NSETS][$];
  resp_t sb [$];

  function automatic int unsigned set_of(input logic [31:0] ip);
    int unsigned h = 0;
    for (int i = 0; i < (32 + AW - 1) / AW; i++) h = h ^ ((ip >> (AW * i)) % NSETS);
    return h;
  endfunction

  function automatic void m_write(input logic [31:0] ip, input logic [47:0] mac);
    int unsigned s = set_of(ip);
    ent_t e;
    e.ip = ip; e.mac = mac;
    for (int i = 0; i < m_set[s].size(); i++) begin
      if (m_set[s][i].ip == ip) begin
        m_set[s].delete(i);
        m_set[s].push_back(e);
        return;
      end
    end
    if (m_set[s].size() == 2) void'(m_set[s].pop_front());
    m_set[s].push_back(e);
  endfunction

  function automatic resp_t m_query(input logic [31:0] ip);
    int unsigned s = set_of(ip);
    ent_t e;
    for (int i = 0; i < m_set[s].size(); i++) begin
      if (m_set[s][i].ip == ip) begin
        e = m_set[s][i];
        m_set[s].delete(i);
        m_set[s].push_back(e);
        return {1'b0, e.mac};
      end
    end
    return {1'b1, 48'h0};
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NSETS; s++) m_set[s].delete();
  endfunction

  // Response consumer: random backpressure unless stalled.
  logic stall = 1'b0;
  initial begin
    bus.query_response_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.query_response_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares presented responses and their stability under backpressure.
  logic  m_hold = 1'b0;
  resp_t m_prev;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_hold = 1'b0;
    end else begin
      if (m_hold) begin
        check("hold_valid", 64'(bus.query_response_valid), 64'd1);
        check("hold_err",   64'(bus.query_response_error), 64'(m_prev.err));
        check("hold_mac",   64'(bus.query_response_mac),   64'(m_prev.mac));
      end
      if (bus.query_response_valid) begin
        check("qready_during_resp", 64'(bus.query_request_ready), 64'd0);
        if (bus.query_response_ready) begin
          m_hold = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_response", 64'd1, 64'd0);
          end else begin
            m_prev = sb.pop_front();
            check("resp_err", 64'(bus.query_response_error), 64'(m_prev.err));
            check("resp_mac", 64'(bus.query_response_mac),   64'(m_prev.mac));
          end
        end else begin
          m_hold = 1'b1;
          m_prev.err = bus.query_response_error;
          m_prev.mac = bus.query_response_mac;
        end
      end else begin
        m_hold = 1'b0;
      end
    end
  end

  task automatic wait_ready(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (is_wr ? bus.write_request_ready : bus.query_request_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(is_wr ? "wr_ready_timeout" : "q_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
    bit ok;
    bus.write_request_ip = ip;
    bus.write_request_mac = mac;
    bus.write_request_valid = 1'b1;
    wait_ready(1'b1, ok);
    bus.write_request_valid = 1'b0;
    if (ok) m_write(ip, mac);
  endtask

  task automatic do_query(input logic [31:0] ip);
    bit ok;
    bus.query_request_ip = ip;
    bus.query_request_valid = 1'b1;
    wait_ready(1'b0, ok);
    bus.query_request_valid = 1'b0;
    if (ok) sb.push_back(m_query(ip));
  endtask

  task automatic pulse_clear();
    bus.clear_cache = 1'b1;
    @(posedge clk); #1;
    bus.clear_cache = 1'b0;
    m_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  localparam logic [31:0] IP_X  = 32'hC0A8010A;
  localparam logic [47:0] MAC_A = 48'hAAAA00000001;
  localparam logic [47:0] MAC_B = 48'hBBBB00000002;
  localparam logic [47:0] MAC_C = 48'hCCCC00000003;
  localparam logic [47:0] MAC_D = 48'hDDDD00000004;

  initial begin
    int cyc;
    bit ok;
    bus.query_request_valid = 1'b0;
    bus.query_request_ip    = '0;
    bus.write_request_valid = 1'b0;
    bus.write_request_ip    = '0;
    bus.write_request_mac   = '0;
    bus.clear_cache         = 1'b0;
    m_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_qready",   64'(bus.query_request_ready),  64'd0);
    check("rst_wready",   64'(bus.write_request_ready),  64'd0);
    check("rst_valid",    64'(bus.query_response_valid), 64'd0);
    check("rst_err",      64'(bus.query_response_error), 64'd0);
    check("rst_mac",      64'(bus.query_response_mac),   64'd0);

    // First ready exactly one sweep after reset release; then a miss.
    @(negedge clk);
    rst_n = 1'b1;
    bus.query_request_ip = IP_X;
    bus.query_request_valid = 1'b1;
    cyc = 0;
    while (!bus.query_request_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_latency", 64'(cyc), 64'(NSETS));
    @(posedge clk); #1;
    bus.query_request_valid = 1'b0;
    sb.push_back(m_query(IP_X));

    // Write then query: response two cycles after acceptance.
    do_write(IP_X, 48'h112233445566);
    do_query(IP_X);
    @(negedge clk); check("lat_c1", 64'(bus.query_response_valid), 64'd0);
    @(negedge clk); check("lat_c2", 64'(bus.query_response_valid), 64'd0);
    @(negedge clk); check("lat_c3", 64'(bus.query_response_valid), 64'd1);
    drain();

    // LRU eviction inside set 5.
    pulse_clear();
    do_write(32'h00000005, MAC_A);
    do_write(32'h00000050, MAC_B);
    do_query(32'h00000005);
    do_write(IP_X, MAC_C);
    do_query(32'h00000050);
    do_query(32'h00000005);
    do_query(IP_X);

    // MAC update does not allocate a new way.
    do_write(32'h00000005, MAC_D);
    do_query(32'h00000005);
    do_query(IP_X);
    do_query(32'h00000050);
    drain();

    // Backpressure with a clear pulse latched during the held response.
    stall = 1'b1;
    @(posedge clk); #1;
    do_query(32'h00000005);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid",  64'(bus.query_response_valid), 64'd1);
      check("stall_qready", 64'(bus.query_request_ready),  64'd0);
      check("stall_wready", 64'(bus.write_request_ready),  64'd0);
      if (i == 4) begin
        @(posedge clk); #1;
        pulse_clear();
      end
    end
    stall = 1'b0;
    drain();
    do_query(32'h00000005);
    do_query(IP_X);
    drain();

    // Reset while a write is in flight.
    do_write(32'h00000077, 48'h0000CAFEF00D);
    do_query(32'h00000077);
    drain();
    bus.write_request_ip = 32'h00001234;
    bus.write_request_mac = 48'h123456789ABC;
    bus.write_request_valid = 1'b1;
    wait_ready(1'b1, ok);
    bus.write_request_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  64'(bus.query_response_valid), 64'd0);
    check("arst_err",    64'(bus.query_response_error), 64'd0);
    check("arst_mac",    64'(bus.query_response_mac),   64'd0);
    check("arst_qready", 64'(bus.query_request_ready),  64'd0);
    check("arst_wready", 64'(bus.write_request_ready),  64'd0);
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_query(32'h00001234);
    do_query(32'h00000077);
    drain();

    // Randomised mix over a small IP pool so sets overflow.
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [31:0] ip;
      op = $urandom_range(0, 99);
      ip = 32'($urandom_range(0, 47));
      if (op < 3)       pulse_clear();
      else if (op < 50) do_write(ip, {16'hBEEF, $urandom()});
      else              do_query(ip);
      if ($urandom_range(0, 7) == 0) @(posedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
